cve2_lsu_lite: RTL

Data-side load/store engine that produces the LSU response stream consumed by the writeback stage (lsu_resp_valid, lsu_resp_err, rf_we_lsu, rf_wdata_lsu). It accepts one access from the ID/EX stage, issues it on the OBI-style data bus, and splits misaligned accesses into two aligned transactions. It reassembles and sign/zero-extends load data and reports bus errors. Only one bus transaction is outstanding at a time.

---
 rtl/cve2_pkg.sv | 34 +++
 rtl/cve2_lsu_data_align.sv | 65 ++++++
 rtl/cve2_lsu_lite.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/cve2_pkg.sv
// Shared types for the lite load/store unit: access size, FSM state and
// small decode helpers used by both the control FSM and the data aligner.
package cve2_pkg;

    typedef enum logic [1:0] {
        LSU_WORD = 2'd0,
        LSU_HALF = 2'd1,
        LSU_BYTE = 2'd2
    } lsu_type_e;

    typedef enum logic [2:0] {
        IDLE            = 3'd0,
        WAIT_GNT_MIS    = 3'd1,
        WAIT_RVALID_MIS = 3'd2,
        WAIT_GNT        = 3'd3,
        WAIT_RVALID     = 3'd4,
        ERR_RESP        = 3'd5
    } lsu_state_e;

    // Encoding 3 on the type input behaves as a byte access.
    function automatic lsu_type_e decode_lsu_type(input logic [1:0] t);
        case (t)
            2'd0:    return LSU_WORD;
            2'd1:    return LSU_HALF;
            default: return LSU_BYTE;
        endcase
    endfunction

    // An access is misaligned when its bytes straddle a word boundary.
    function automatic logic is_misaligned(input lsu_type_e t, input logic [1:0] o);
        return ((t == LSU_WORD) && (o != 2'd0)) || ((t == LSU_HALF) && (o == 2'd3));
    endfunction

endpackage

// File: rtl/cve2_lsu_data_align.sv
// Combinational lane steering: byte enables, store-data rotation and load
// reassembly with sign/zero extension.
module cve2_lsu_data_align
    import cve2_pkg::*;
(
    input  lsu_type_e   type_i,
    input  logic [1:0]  offset_i,
    input  logic        second_i,
    input  logic        misaligned_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_lo_i,
    input  logic [31:0] rdata_hi_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_rot_o,
    output logic [31:0] load_data_o
);

    logic [2:0]  word_tail_shift;
    logic [63:0] rdata_dbl;
    logic [31:0] rdata_shifted;

    assign word_tail_shift = 3'd4 - {1'b0, offset_i};

    // Byte enables for the first or second aligned word of the access.
    always_comb begin
        be_o = 4'b0000;
        case (type_i)
            LSU_WORD: be_o = second_i ? (4'b1111 >> word_tail_shift) : (4'b1111 << offset_i);
            LSU_HALF: begin
                if (offset_i == 2'd3) begin
                    be_o = second_i ? 4'b0001 : 4'b1000;
                end else begin
                    be_o = 4'b0011 << offset_i;
                end
            end
            default:  be_o = 4'b0001 << offset_i;
        endcase
    end

    // Rotate store data so byte 0 lands on lane offset_i; both halves of a
    // split access reuse the same rotated word.
    always_comb begin
        wdata_rot_o = wdata_i;
        case (offset_i)
            2'd1:    wdata_rot_o = {wdata_i[23:0], wdata_i[31:24]};
            2'd2:    wdata_rot_o = {wdata_i[15:0], wdata_i[31:16]};
            2'd3:    wdata_rot_o = {wdata_i[7:0],  wdata_i[31:8]};
            default: wdata_rot_o = wdata_i;
        endcase
    end

    // Stitch both beats of a split load together, shift to the access
    // offset, then extend to 32 bits according to the access size.
    always_comb begin
        rdata_dbl     = misaligned_i ? {rdata_hi_i, rdata_lo_i} : {32'h0, rdata_hi_i};
        rdata_shifted = 32'(rdata_dbl >> {offset_i, 3'b000});
        case (type_i)
            LSU_WORD: load_data_o = rdata_shifted;
            LSU_HALF: load_data_o = {{16{sign_ext_i & rdata_shifted[15]}}, rdata_shifted[15:0]};
            default:  load_data_o = {{24{sign_ext_i & rdata_shifted[7]}}, rdata_shifted[7:0]};
        endcase
    end

endmodule

// File: rtl/cve2_lsu_lite.sv
// Load/store unit: single outstanding OBI-style transaction, misaligned
// accesses optionally split into two aligned beats, one response per access.
module cve2_lsu_lite
    import cve2_pkg::*;
#(
    parameter bit MisalignedEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [1:0]  lsu_type_i,
    input  logic        lsu_sign_ext_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_req_done_o,
    output logic        lsu_busy_o,
    output logic        lsu_resp_valid_o,
    output logic        lsu_resp_err_o,
    output logic        rf_we_lsu_o,
    output logic [31:0] rf_wdata_lsu_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    lsu_type_e   type_q, type_d;
    logic        sign_q, sign_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] cur_addr;
    logic        cur_we;
    lsu_type_e   cur_type;
    logic [31:0] cur_wdata;
    logic        cur_mis;
    logic        second_beat;
    logic        req;
    logic        resp_valid;
    logic        resp_err;
    logic        rf_we;
    logic [3:0]  be;
    logic [31:0] wdata_rot;
    logic [31:0] load_data;

    // In IDLE the request comes straight from EX; afterwards from the capture.
    assign cur_addr    = (state_q == IDLE) ? lsu_addr_i  : addr_q;
    assign cur_we      = (state_q == IDLE) ? lsu_we_i    : we_q;
    assign cur_type    = (state_q == IDLE) ? decode_lsu_type(lsu_type_i) : type_q;
    assign cur_wdata   = (state_q == IDLE) ? lsu_wdata_i : wdata_q;
    assign cur_mis     = is_misaligned(cur_type, cur_addr[1:0]);
    assign second_beat = (state_q != IDLE) && (state_q != WAIT_GNT_MIS) && cur_mis;

    cve2_lsu_data_align u_align (
        .type_i       (cur_type),
        .offset_i     (cur_addr[1:0]),
        .second_i     (second_beat),
        .misaligned_i (cur_mis),
        .sign_ext_i   (sign_q),
        .wdata_i      (cur_wdata),
        .rdata_lo_i   (rdata_q),
        .rdata_hi_i   (data_rdata_i),
        .be_o         (be),
        .wdata_rot_o  (wdata_rot),
        .load_data_o  (load_data)
    );

    // Next-state, capture and handshake decode.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        we_d           = we_q;
        type_d         = type_q;
        sign_d         = sign_q;
        wdata_d        = wdata_q;
        err_d          = err_q;
        rdata_d        = rdata_q;
        req            = 1'b0;
        lsu_req_done_o = 1'b0;
        resp_valid     = 1'b0;
        resp_err       = 1'b0;
        case (state_q)
            IDLE: begin
                if (lsu_req_i) begin
                    addr_d  = lsu_addr_i;
                    we_d    = lsu_we_i;
                    type_d  = decode_lsu_type(lsu_type_i);
                    sign_d  = lsu_sign_ext_i;
                    wdata_d = lsu_wdata_i;
                    err_d   = 1'b0;
                    if (cur_mis && !MisalignedEn) begin
                        state_d = ERR_RESP;
                    end else if (cur_mis) begin
                        req     = 1'b1;
                        state_d = data_gnt_i ? WAIT_RVALID_MIS : WAIT_GNT_MIS;
                    end else begin
                        req            = 1'b1;
                        lsu_req_done_o = data_gnt_i;
                        state_d        = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                    end
                end
            end
            WAIT_GNT_MIS: begin
                req = 1'b1;
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID_MIS;
                end
            end
            WAIT_RVALID_MIS: begin
                // First beat returns; the second beat is requested immediately
                // even if the first one faulted.
                if (data_rvalid_i) begin
                    rdata_d        = data_rdata_i;
                    err_d          = err_q | data_err_i;
                    req            = 1'b1;
                    lsu_req_done_o = data_gnt_i;
                    state_d        = data_gnt_i ? WAIT_RVALID : WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                req = 1'b1;
                if (data_gnt_i) begin
                    lsu_req_done_o = 1'b1;
                    state_d        = WAIT_RVALID;
                end
            end
            WAIT_RVALID: begin
                if (data_rvalid_i) begin
                    resp_valid = 1'b1;
                    resp_err   = err_q | data_err_i;
                    state_d    = IDLE;
                end
            end
            ERR_RESP: begin
                resp_valid     = 1'b1;
                resp_err       = 1'b1;
                lsu_req_done_o = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            we_q    <= 1'b0;
            type_q  <= LSU_WORD;
            sign_q  <= 1'b0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            type_q  <= type_d;
            sign_q  <= sign_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign rf_we = resp_valid & ~we_q & ~resp_err;

    assign lsu_busy_o       = (state_q != IDLE);
    assign lsu_resp_valid_o = resp_valid;
    assign lsu_resp_err_o   = resp_err;
    assign rf_we_lsu_o      = rf_we;
    assign rf_wdata_lsu_o   = rf_we ? load_data : 32'h0;

    // Bus attributes are quiet whenever no request is on the bus.
    assign data_req_o   = req;
    assign data_addr_o  = req ? {cur_addr[31:2] + 30'(second_beat), 2'b00} : 32'h0;
    assign data_we_o    = req & cur_we;
    assign data_be_o    = req ? be : 4'b0000;
    assign data_wdata_o = req ? wdata_rot : 32'h0;

endmodule
